neopixel_controller: RTL and testbench

NEOPIXEL_CONTROLLER -- requirements
Module: neopixel_controller

---
 rtl/neopixel_pkg.sv | 38 +++
 rtl/neo_bit_timer.sv | 30 +++
 rtl/neopixel_counter.sv | 23 ++
 rtl/neopixel_controller.sv | 142 ++++++++++++++
 tb/tb_neopixel_controller.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/neopixel_pkg.sv
// rtl/neopixel_pkg.sv - shared WS2812 timing constants, enums and buffer helper
package neopixel_pkg;

    localparam int T0H                = 18;
    localparam int T1H                = 35;
    localparam int TBIT               = 63;
    localparam int TLATCH             = 2500;
    localparam int NUM_PIXELS_DEFAULT = 5;

    typedef enum logic [1:0] {
        CH_G = 2'd0,
        CH_R = 2'd1,
        CH_B = 2'd2
    } channel_t;

    typedef enum logic [1:0] {
        IDLE,
        BIT_HIGH,
        BIT_LOW,
        LATCH
    } state_t;

    // Replace one byte of a GRB word; the reserved channel leaves it untouched.
    function automatic logic [23:0] set_channel(input logic [23:0] grb,
                                                input logic [1:0]  ch,
                                                input logic [7:0]  level);
        logic [23:0] r;
        r = grb;
        case (channel_t'(ch))
            CH_G:    r[23:16] = level;
            CH_R:    r[15:8]  = level;
            CH_B:    r[7:0]   = level;
            default: r        = grb;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/neo_bit_timer.sv
// rtl/neo_bit_timer.sv - per-bit WS2812 timer producing high-phase and bit-done
module neo_bit_timer
    import neopixel_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic bit_value,
    output logic high,
    output logic done
);

    logic [5:0] t;
    logic [5:0] high_last;

    assign high_last = bit_value ? 6'(T1H - 1) : 6'(T0H - 1);
    assign done      = (t == 6'(TBIT - 1));
    // High phase still continues on the following cycle.
    assign high      = (t < high_last);

    neopixel_counter #(.W(6)) u_bit_cnt (
        .clock (clock),
        .reset (reset),
        .en    (1'b1),
        .clear (start),
        .d     (done ? 6'd0 : t + 6'd1),
        .q     (t)
    );

endmodule

// File: rtl/neopixel_counter.sv
// rtl/neopixel_counter.sv - loadable counter register with enable and clear
module neopixel_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/neopixel_controller.sv
// rtl/neopixel_controller.sv - WS2812 strip controller with pixel buffer and serializer
module neopixel_controller
    import neopixel_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int NUM_PIXELS = NUM_PIXELS_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_it,
    input  logic [2:0] pixel_index,
    input  logic [1:0] color_index,
    input  logic [7:0] color_level,
    input  logic       send_it,
    output logic       ready_to_load,
    output logic       ready_to_send,
    output logic       neo_data
);

    state_t      state;
    logic [23:0] buffer [NUM_PIXELS];
    logic [23:0] word;
    logic [4:0]  bit_cnt;
    logic [2:0]  pix_cnt;
    logic [2:0]  next_pix;
    logic [11:0] latch_cnt;
    logic        high;
    logic        done;

    logic        idle;
    logic        load_ok;
    logic        accept;
    logic        bit_end;
    logic        last_bit;
    logic        last_pix;
    logic        latch_end;
    logic [23:0] load_word;
    logic [23:0] first_word;

    assign idle          = (state == IDLE);
    assign ready_to_load = idle;
    assign ready_to_send = idle;

    assign load_ok   = idle && load_it && (32'(pixel_index) < NUM_PIXELS) && (color_index != 2'd3);
    assign accept    = idle && send_it;
    assign bit_end   = (state == BIT_LOW) && done;
    assign last_bit  = (bit_cnt == 5'd23);
    assign last_pix  = (32'(pix_cnt) == NUM_PIXELS - 1);
    assign next_pix  = last_pix ? 3'd0 : pix_cnt + 3'd1;
    assign latch_end = (state == LATCH) && (latch_cnt == 12'(TLATCH - 1));

    assign load_word  = set_channel(buffer[pixel_index], color_index, color_level);
    // A load in the accepting cycle must appear in the frame, so forward it.
    assign first_word = (load_ok && pixel_index == 3'd0) ? load_word : buffer[0];

    neo_bit_timer u_timer (
        .clock     (clock),
        .reset     (reset),
        .start     (accept),
        .bit_value (word[23]),
        .high      (high),
        .done      (done)
    );

    neopixel_counter #(.W(5)) u_bit_counter (
        .clock (clock),
        .reset (reset),
        .en    (bit_end),
        .clear (accept),
        .d     (last_bit ? 5'd0 : bit_cnt + 5'd1),
        .q     (bit_cnt)
    );

    neopixel_counter #(.W(3)) u_pix_counter (
        .clock (clock),
        .reset (reset),
        .en    (bit_end && last_bit),
        .clear (accept),
        .d     (next_pix),
        .q     (pix_cnt)
    );

    neopixel_counter #(.W(12)) u_latch_counter (
        .clock (clock),
        .reset (reset),
        .en    (state == LATCH),
        .clear (latch_end),
        .d     (latch_cnt + 12'd1),
        .q     (latch_cnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            neo_data <= 1'b0;
            word     <= '0;
            for (int i = 0; i < NUM_PIXELS; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            if (load_ok) begin
                buffer[pixel_index] <= load_word;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= BIT_HIGH;
                        neo_data <= 1'b1;
                        word     <= first_word;
                    end
                end
                BIT_HIGH: begin
                    if (!high) begin
                        state    <= BIT_LOW;
                        neo_data <= 1'b0;
                    end
                end
                BIT_LOW: begin
                    if (done) begin
                        if (last_bit && last_pix) begin
                            state <= LATCH;
                        end else begin
                            state    <= BIT_HIGH;
                            neo_data <= 1'b1;
                            word     <= last_bit ? buffer[next_pix] : {word[22:0], 1'b0};
                        end
                    end
                end
                LATCH: begin
                    if (latch_end) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    neo_data <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_controller.sv
// tb/tb_neopixel_controller.sv - directed self-checking bench for neopixel_controller
module tb_neopixel_controller;

    logic       clock;
    logic       reset;
    logic       load_it;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       send_it;
    logic       ready_to_load;
    logic       ready_to_send;
    logic       neo_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] pix;
        logic [1:0] col;
        logic [7:0] lvl;
        logic       exp_rdy;
    } load_vec_t;

    load_vec_t vecs [6];

    neopixel_controller #(.CLK_HZ(50_000_000), .NUM_PIXELS(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .load_it       (load_it),
        .pixel_index   (pixel_index),
        .color_index   (color_index),
        .color_level   (color_level),
        .send_it       (send_it),
        .ready_to_load (ready_to_load),
        .ready_to_send (ready_to_send),
        .neo_data      (neo_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_bit(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, expv);
        end
    endtask

    // Entered and left on a falling edge.
    task automatic do_load(input logic [2:0] p, input logic [1:0] c, input logic [7:0] v);
        load_it = 1'b1; pixel_index = p; color_index = c; color_level = v;
        @(posedge clock);
        #1 load_it = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Entered on a falling edge, returns just after the accepting rising edge.
    task automatic send_start(input logic with_load, input logic [2:0] p,
                              input logic [1:0] c, input logic [7:0] v);
        check_bit("ready_to_send before send", ready_to_send, 1'b1);
        send_it = 1'b1;
        load_it = with_load; pixel_index = p; color_index = c; color_level = v;
        @(posedge clock);
        #1 send_it = 1'b0;
        load_it = 1'b0;
    endtask

    // Samples every falling edge of the frame; returns on a falling edge in IDLE.
    task automatic check_frame(input logic [119:0] exp, input string tag);
        int   h;
        int   exp_h;
        logic stray;
        logic busy_bad;
        logic latch_bad;
        busy_bad = 1'b0;
        for (int k = 0; k < 120; k++) begin
            h = 0;
            stray = 1'b0;
            for (int c = 0; c < 63; c++) begin
                @(negedge clock);
                if (ready_to_load || ready_to_send) busy_bad = 1'b1;
                if (neo_data) begin
                    if (c == h) h++;
                    else stray = 1'b1;
                end
            end
            exp_h = exp[119-k] ? 35 : 18;
            checks++;
            if (h != exp_h || stray) begin
                errors++;
                $display("FAIL %s bit %0d: high %0d cycles (stray high %b), expected %0d",
                         tag, k, h, stray, exp_h);
            end
        end
        latch_bad = 1'b0;
        repeat (2500) begin
            @(negedge clock);
            if (neo_data) latch_bad = 1'b1;
            if (ready_to_load || ready_to_send) busy_bad = 1'b1;
        end
        check_bit({tag, " latch low"}, latch_bad, 1'b0);
        check_bit({tag, " ready low during frame"}, busy_bad, 1'b0);
        @(negedge clock);
        check_bit({tag, " ready_to_load after latch"}, ready_to_load, 1'b1);
        check_bit({tag, " ready_to_send after latch"}, ready_to_send, 1'b1);
    endtask

    initial begin
        reset = 1'b0; load_it = 1'b0; send_it = 1'b0;
        pixel_index = '0; color_index = '0; color_level = '0;

        vecs[0] = '{3'd0, 2'd0, 8'hFF, 1'b1};
        vecs[1] = '{3'd2, 2'd1, 8'hA5, 1'b1};
        vecs[2] = '{3'd4, 2'd2, 8'h3C, 1'b1};
        vecs[3] = '{3'd5, 2'd0, 8'hFF, 1'b1};
        vecs[4] = '{3'd1, 2'd3, 8'hFF, 1'b1};
        vecs[5] = '{3'd7, 2'd2, 8'hFF, 1'b1};

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            load_it = 1'($urandom); send_it = 1'($urandom);
            pixel_index = 3'($urandom); color_index = 2'($urandom); color_level = 8'($urandom);
            #1;
            check_bit("reset neo_data", neo_data, 1'b0);
            check_bit("reset ready_to_load", ready_to_load, 1'b1);
            check_bit("reset ready_to_send", ready_to_send, 1'b1);
        end
        @(negedge clock);
        load_it = 1'b0; send_it = 1'b0;
        reset = 1'b1;

        // Table of loads from the first edge after release, then one frame.
        for (int i = 0; i < 6; i++) begin
            check_bit($sformatf("ready_to_load vec %0d", i), ready_to_load, vecs[i].exp_rdy);
            do_load(vecs[i].pix, vecs[i].col, vecs[i].lvl);
        end
        send_start(1'b0, 3'd0, 2'd0, 8'd0);
        check_frame({24'hFF0000, 24'h000000, 24'h00A500, 24'h000000, 24'h00003C}, "table");

        // Single frame with loads and a send attempt while pixel 2 is on the line.
        do_reset();
        do_load(3'd0, 2'd0, 8'h80);
        send_start(1'b0, 3'd0, 2'd0, 8'd0);
        fork
            check_frame({24'h800000, 96'd0}, "single");
            begin
                repeat (3100) @(negedge clock);
                load_it = 1'b1; send_it = 1'b1;
                pixel_index = 3'd0; color_index = 2'd0; color_level = 8'hFF;
                repeat (4) @(negedge clock);
                load_it = 1'b0; send_it = 1'b0;
            end
        join
        send_start(1'b0, 3'd0, 2'd0, 8'd0);
        check_frame({24'h800000, 96'd0}, "repeat");

        // Out-of-range pixel and reserved channel loads.
        do_reset();
        do_load(3'd5, 2'd0, 8'hFF);
        do_load(3'd0, 2'd3, 8'hFF);
        send_start(1'b0, 3'd0, 2'd0, 8'd0);
        check_frame(120'd0, "ignored");

        // Load and send in the same IDLE cycle.
        do_reset();
        send_start(1'b1, 3'd0, 2'd2, 8'h01);
        check_frame({24'h000001, 96'd0}, "simultaneous");

        // Reset in the 3000th cycle of a frame.
        do_reset();
        do_load(3'd0, 2'd0, 8'hFF);
        do_load(3'd3, 2'd1, 8'h55);
        send_start(1'b0, 3'd0, 2'd0, 8'd0);
        repeat (2999) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check_bit("midframe reset neo_data", neo_data, 1'b0);
        check_bit("midframe reset ready_to_load", ready_to_load, 1'b1);
        check_bit("midframe reset ready_to_send", ready_to_send, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        send_start(1'b0, 3'd0, 2'd0, 8'd0);
        check_frame(120'd0, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
